// File: rtl/mod_majority_core_if.sv
// Handshake/data bundle for mod_majority_core: operand words, combinational and
// registered results, valid/ready pairs. OP exists only with MOD_MAJORITY_CH_EN.
interface mod_majority_core_if #(
  parameter int WIDTH = 32
);
  logic [0:WIDTH-1] E;
  logic [0:WIDTH-1] F;
  logic [0:WIDTH-1] G;
  logic [0:WIDTH-1] Y;
  logic             in_valid;
  logic             in_ready;
  logic [0:WIDTH-1] Y_Q;
  logic             out_valid;
  logic             out_ready;
`ifdef MOD_MAJORITY_CH_EN
  logic             OP;
`endif

  modport master (
    output E, F, G, in_valid, out_ready,
`ifdef MOD_MAJORITY_CH_EN
    output OP,
`endif
    input  Y, in_ready, Y_Q, out_valid
  );

  modport slave (
    input  E, F, G, in_valid, out_ready,
`ifdef MOD_MAJORITY_CH_EN
    input  OP,
`endif
    output Y, in_ready, Y_Q, out_valid
  );
endinterface

// File: rtl/mod_majority_core.sv
// Bitwise majority (optionally SHA-256 choose when MOD_MAJORITY_CH_EN is defined)
// with a combinational output and a one-deep valid/ready output register.
module mod_majority_core #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  mod_majority_core_if.slave  bus
);

  logic [0:WIDTH-1] y_c;
  logic [0:WIDTH-1] y_q;
  logic             out_valid_q;
  logic             accept;

  always_comb begin
    y_c = (bus.E & bus.F) | (bus.E & bus.G) | (bus.F & bus.G);
`ifdef MOD_MAJORITY_CH_EN
    if (bus.OP) begin
      y_c = (bus.E & bus.F) | (~bus.E & bus.G);
    end
`endif
  end

  // The output register is the only storage, so space opens as soon as it drains.
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      y_q         <= y_c;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.Y         = y_c;
  assign bus.Y_Q       = y_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mod_majority_core.sv
// Self-checking bench for mod_majority_core: directed vectors, handshake
// scenarios and a randomized run against a per-bit vote/select reference model.
module tb_mod_majority_core;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod_majority_core_if #(.WIDTH(WIDTH)) bus ();
  mod_majority_core #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [0:WIDTH-1] vec_e [5] = '{32'hFFFFFFFF, 32'hFFFF0000, 32'hF0F0F0F0, 32'hCCCCCCCC, 32'hAAAAAAAA};
  logic [0:WIDTH-1] vec_f [5] = '{32'hFFFF0000, 32'hF0F0F0F0, 32'hFC60039F, 32'hAAAAAAAA, 32'hA5A5A5A5};
  logic [0:WIDTH-1] vec_g [5] = '{32'hF0F0F0F0, 32'hCCCCCCCC, 32'hA5A5A5A5, 32'hFFFF0000, 32'hFC60039F};
  logic [0:WIDTH-1] vec_y [5] = '{32'hFFFFF0F0, 32'hFCFCC0C0, 32'hF4E0A1B5, 32'hEEEE8888, 32'hACA0A3AF};

  // Reference: each bit is a vote of three (majority) or E picks F over G (choose).
  function automatic logic [0:WIDTH-1] ref_fn(input logic [0:WIDTH-1] e, input logic [0:WIDTH-1] f,
                                               input logic [0:WIDTH-1] g, input logic op);
    logic [0:WIDTH-1] r;
    int n;
    for (int i = 0; i < WIDTH; i++) begin
      n = int'(e[i]) + int'(f[i]) + int'(g[i]);
      if (op) r[i] = e[i] ? f[i] : g[i];
      else    r[i] = (n >= 2);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [0:WIDTH-1] e, input logic [0:WIDTH-1] f, input logic [0:WIDTH-1] g,
                       input logic v, input logic r, input logic op);
    bus.E = e;
    bus.F = f;
    bus.G = g;
    bus.in_valid  = v;
    bus.out_ready = r;
`ifdef MOD_MAJORITY_CH_EN
    bus.OP = op;
`else
    if (op) begin end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(vec_e[0], vec_f[0], vec_g[0], 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.Y_Q !== 32'h0) begin errors++; $display("FAIL reset_y_q got %h want 00000000", bus.Y_Q); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_comb_vectors();
    for (int i = 0; i < 5; i++) begin
      drive(vec_e[i], vec_f[i], vec_g[i], 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.Y !== vec_y[i]) begin errors++; $display("FAIL comb_y[%0d] got %h want %h", i, bus.Y, vec_y[i]); end
    end
    rst = 1'b1;
    drive(vec_e[1], vec_f[1], vec_g[1], 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.Y !== vec_y[1]) begin errors++; $display("FAIL comb_y_in_reset got %h want %h", bus.Y, vec_y[1]); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      drive(vec_e[i], vec_f[i], vec_g[i], 1'b1, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, bus.in_ready); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid[%0d] got %b want 1", i, bus.out_valid); end
      checks++;
      if (bus.Y_Q !== vec_y[i]) begin errors++; $display("FAIL b2b_y_q[%0d] got %h want %h", i, bus.Y_Q, vec_y[i]); end
    end
    drive(vec_e[0], vec_f[0], vec_g[0], 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
    checks++;
    if (bus.Y_Q !== vec_y[4]) begin errors++; $display("FAIL b2b_drain_y_q got %h want %h", bus.Y_Q, vec_y[4]); end
  endtask

  task automatic test_backpressure();
    drive(vec_e[0], vec_f[0], vec_g[0], 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.Y_Q !== 32'hFFFFF0F0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_accept got y_q=%h v=%b want FFFFF0F0 1", bus.Y_Q, bus.out_valid);
    end
    drive(vec_e[3], vec_f[3], vec_g[3], 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, bus.in_ready); end
      tick();
      checks++;
      if (bus.Y_Q !== 32'hFFFFF0F0 || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got y_q=%h v=%b want FFFFF0F0 1", c, bus.Y_Q, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
    tick();
    checks++;
    if (bus.Y_Q !== vec_y[3] || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_next got y_q=%h v=%b want %h 1", bus.Y_Q, bus.out_valid, vec_y[3]);
    end
    drive(vec_e[0], vec_f[0], vec_g[0], 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset_pending();
    drive(vec_e[1], vec_f[1], vec_g[1], 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rp_pending got %b want 1", bus.out_valid); end
    rst = 1'b1;
    drive(vec_e[2], vec_f[2], vec_g[2], 1'b1, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Y_Q !== 32'h0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rp_cleared got v=%b y_q=%h rdy=%b want 0 00000000 1", bus.out_valid, bus.Y_Q, bus.in_ready);
    end
  endtask

`ifdef MOD_MAJORITY_CH_EN
  task automatic test_choose();
    drive(32'hFFFF0000, 32'hF0F0F0F0, 32'hCCCCCCCC, 1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if (bus.Y !== 32'hF0F0CCCC) begin errors++; $display("FAIL ch_y got %h want F0F0CCCC", bus.Y); end
    tick();
    bus.OP = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.Y_Q !== 32'hF0F0CCCC || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL ch_y_q got %h v=%b want F0F0CCCC 1", bus.Y_Q, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    tick();
  endtask
`endif

  task automatic test_random();
    logic             m_valid;
    logic [0:WIDTH-1] m_q;
    logic [0:WIDTH-1] e, f, g;
    logic             v, r, op, rs, exp_rdy;
    rst = 1'b1;
    tick();
    m_valid = 1'b0;
    m_q = '0;
    for (int n = 0; n < 300; n++) begin
      e  = $urandom;
      f  = $urandom;
      g  = $urandom;
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 19) == 0);
`ifdef MOD_MAJORITY_CH_EN
      op = $urandom_range(0, 1) == 1;
`else
      op = 1'b0;
`endif
      rst = rs;
      drive(e, f, g, v, r, op);
      #1;
      exp_rdy = !m_valid || r;
      checks++;
      if (bus.Y !== ref_fn(e, f, g, op)) begin
        errors++; $display("FAIL rnd_y[%0d] got %h want %h", n, bus.Y, ref_fn(e, f, g, op));
      end
      checks++;
      if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b want %b", n, bus.in_ready, exp_rdy); end
      tick();
      if (rs) begin
        m_valid = 1'b0;
        m_q = '0;
      end else if (v && exp_rdy) begin
        m_valid = 1'b1;
        m_q = ref_fn(e, f, g, op);
      end else if (r) begin
        m_valid = 1'b0;
      end
      checks++;
      if (bus.out_valid !== m_valid) begin errors++; $display("FAIL rnd_out_valid[%0d] got %b want %b", n, bus.out_valid, m_valid); end
      checks++;
      if (bus.Y_Q !== m_q) begin errors++; $display("FAIL rnd_y_q[%0d] got %h want %h", n, bus.Y_Q, m_q); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_comb_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_pending();
`ifdef MOD_MAJORITY_CH_EN
    test_choose();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
